// File: rtl/serial_arith_pkg.sv
// Shared encodings for the bit-serial arithmetic blocks.
// Code 2'd3 is unused and every decoder treats it as IDLE.
package serial_arith_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_ADD    = 2'd1;
    localparam state_t S_DONE   = 2'd2;
    localparam state_t S_UNUSED = 2'd3;

    localparam int SERIAL_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/Full_Adder.sv
// Single-bit full adder cell: the only arithmetic in the serial adder.
module Full_Adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one Full_Adder plus a carry flop, LSB first, WIDTH+1 cycle latency.
// Result bits shift in at the MSB so the finished sum lands aligned.
module serial_adder
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] operand_one,
    input  logic [WIDTH-1:0] operand_two,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_sum,
    output logic             result_carry
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    state_t             state_r;
    state_t             next_state_s;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   sum_r;
    logic               c_r;
    logic               carry_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               busy_r;
    logic               done_r;
    logic               busy_s;
    logic               done_s;
    logic               fa_sum_s;
    logic               fa_carry_s;
    logic               last_bit_s;

    Full_Adder bit_add (
        .a     (a_r[0]),
        .b     (b_r[0]),
        .c_in  (c_r),
        .sum   (fa_sum_s),
        .c_out (fa_carry_s)
    );

    assign last_bit_s = (cnt_r == CNT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        next_state_s = S_IDLE;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    next_state_s = S_ADD;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_ADD: begin
                if (last_bit_s) begin
                    next_state_s = S_DONE;
                end else begin
                    next_state_s = S_ADD;
                end
            end
            S_DONE: begin
                next_state_s = S_IDLE;
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so busy/done come straight off flops.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (next_state_s)
            S_ADD: begin
                busy_s = 1'b1;
                done_s = 1'b0;
            end
            S_DONE: begin
                busy_s = 1'b0;
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Status output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_s;
            done_r <= done_s;
        end
    end

    // Operand shifters, carry flop, bit counter and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            c_r     <= 1'b0;
            carry_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        a_r   <= operand_one;
                        b_r   <= operand_two;
                        c_r   <= carry_in;
                        cnt_r <= {CNT_W{1'b0}};
                    end
                end
                S_ADD: begin
                    a_r   <= {1'b0, a_r[WIDTH-1:1]};
                    b_r   <= {1'b0, b_r[WIDTH-1:1]};
                    sum_r <= {fa_sum_s, sum_r[WIDTH-1:1]};
                    c_r   <= fa_carry_s;
                    // Counter parks on the last index rather than wrapping.
                    if (last_bit_s) begin
                        carry_r <= fa_carry_s;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    a_r <= a_r;
                end
            endcase
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign result_sum   = sum_r;
    assign result_carry = carry_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH = 2, 8 and 32.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start2, start8, start32;
    logic [31:0] opa, opb;
    logic        cin;

    logic        busy2, done2, carry2;
    logic [1:0]  sum2;
    logic        busy8, done8, carry8;
    logic [7:0]  sum8;
    logic        busy32, done32, carry32;
    logic [31:0] sum32;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2),
        .operand_one(opa[1:0]), .operand_two(opb[1:0]), .carry_in(cin),
        .busy(busy2), .done(done2), .result_sum(sum2), .result_carry(carry2)
    );

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8),
        .operand_one(opa[7:0]), .operand_two(opb[7:0]), .carry_in(cin),
        .busy(busy8), .done(done8), .result_sum(sum8), .result_carry(carry8)
    );

    serial_adder #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset(reset), .start(start32),
        .operand_one(opa), .operand_two(opb), .carry_in(cin),
        .busy(busy32), .done(done32), .result_sum(sum32), .result_carry(carry32)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // {busy, done, carry, sum zero-extended to 32 bits}
    function automatic logic [34:0] obs(input int w);
        case (w)
            2:       obs = {busy2, done2, carry2, 30'd0, sum2};
            8:       obs = {busy8, done8, carry8, 24'd0, sum8};
            default: obs = {busy32, done32, carry32, sum32};
        endcase
    endfunction

    task automatic set_start(input int w, input logic v);
        case (w)
            2:       start2 = v;
            8:       start8 = v;
            default: start32 = v;
        endcase
    endtask

    function automatic logic [32:0] model(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic c);
        logic [31:0] m;
        logic [32:0] full;
        m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        full = {1'b0, a & m} + {1'b0, b & m} + {32'd0, c};
        model = {full[w], full[31:0] & m};
    endfunction

    // One operation with cycle-exact busy/done checks; start is re-pulsed
    // with scrambled operands at cycles ign1/ign2 to prove it is ignored.
    task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic [31:0] es, input logic ec,
                          input int ign1, input int ign2, input string tag);
        logic [34:0] o;
        @(negedge clk);
        opa = a; opb = b; cin = c;
        set_start(w, 1'b1);
        for (int cyc = 1; cyc <= w + 3; cyc++) begin
            @(negedge clk);
            o = obs(w);
            check({tag, " busy"}, 64'(o[34]), 64'(cyc <= w));
            check({tag, " done"}, 64'(o[33]), 64'(cyc == w + 1));
            if (cyc >= w + 1) begin
                check({tag, " sum"},   64'(o[31:0]), 64'(es));
                check({tag, " carry"}, 64'(o[32]),   64'(ec));
            end
            opa = a ^ 32'h5A5A_5A5A; opb = ~b; cin = ~c;
            set_start(w, (cyc == ign1) || (cyc == ign2));
        end
        set_start(w, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [34:0] o;
        logic [32:0] e;
        logic [31:0] ra, rb;
        logic        rc;

        reset = 1'b1; start2 = 1'b0; start8 = 1'b0; start32 = 1'b0;
        opa = 32'd0; opb = 32'd0; cin = 1'b0;
        repeat (3) @(negedge clk);
        check("reset w2",  64'(obs(2)),  64'd0);
        check("reset w8",  64'(obs(8)),  64'd0);
        check("reset w32", 64'(obs(32)), 64'd0);
        reset = 1'b0;

        // Hand-computed directed vectors at WIDTH=8.
        run_op(8, 32'h5A, 32'h3C, 1'b0, 32'h96, 1'b0, 0, 0, "5a+3c");
        run_op(8, 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, 0, 0, "ff+01");
        run_op(8, 32'hFF, 32'hFF, 1'b1, 32'hFF, 1'b1, 0, 0, "ff+ff+1");
        run_op(8, 32'h12, 32'h34, 1'b0, 32'h46, 1'b0, 3, 9, "ignore_start");

        // Reset in cycle 4 of an operation discards it.
        @(negedge clk);
        opa = 32'h77; opb = 32'h11; cin = 1'b0; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        o = obs(8);
        check("midreset busy",  64'(o[34]),   64'd0);
        check("midreset done",  64'(o[33]),   64'd0);
        check("midreset sum",   64'(o[31:0]), 64'd0);
        check("midreset carry", 64'(o[32]),   64'd0);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            o = obs(8);
            check("after reset idle", 64'(o[34:33]), 64'd0);
        end
        run_op(8, 32'h01, 32'h01, 1'b0, 32'h02, 1'b0, 0, 0, "01+01");

        // Reset and start together: reset wins.
        @(negedge clk); reset = 1'b1; start8 = 1'b1; opa = 32'h3; opb = 32'h4;
        @(negedge clk); reset = 1'b0; start8 = 1'b0;
        @(negedge clk);
        o = obs(8);
        check("reset+start busy", 64'(o[34]), 64'd0);
        check("reset+start sum",  64'(o[31:0]), 64'd0);

        // Start held high: accepts at edges 0 and 10.
        @(negedge clk);
        opa = 32'h80; opb = 32'h80; cin = 1'b0; start8 = 1'b1;
        for (int cyc = 1; cyc <= 21; cyc++) begin
            @(negedge clk);
            o = obs(8);
            check("b2b busy", 64'(o[34]),
                  64'(((cyc >= 1) && (cyc <= 8)) || ((cyc >= 11) && (cyc <= 18))));
            check("b2b done", 64'(o[33]), 64'((cyc == 9) || (cyc == 19)));
            if ((cyc >= 9 && cyc <= 11) || cyc >= 19) begin
                check("b2b sum",   64'(o[31:0]), 64'h00);
                check("b2b carry", 64'(o[32]),   64'd1);
            end
            if (cyc == 19) start8 = 1'b0;
        end

        // Random operands at WIDTH=8 against a + b + cin.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
            e = model(8, ra, rb, rc);
            run_op(8, ra, rb, rc, e[31:0], e[32], 0, 0, "rand w8");
        end

        // Exhaustive at WIDTH=2 (one-bit counter).
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                for (int c = 0; c < 2; c++) begin
                    e = model(2, 32'(a), 32'(b), 1'(c));
                    run_op(2, 32'(a), 32'(b), 1'(c), e[31:0], e[32], 0, 0, "w2");
                end
            end
        end

        // WIDTH=32: full-carry boundary, then random operands.
        run_op(32, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 1'b1, 0, 0, "w32 ffffffff+0+1");
        run_op(32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 0, 0, "w32 max");
        for (int i = 0; i < 20; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
            e = model(32, ra, rb, rc);
            run_op(32, ra, rb, rc, e[31:0], e[32], 0, 0, "rand w32");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
